// File: rtl/td_mac_sequencer.sv
// td_mac_sequencer - sequences one time-domain MAC on the analog neuron cell
// Pulse-width drives din/win, measures the cell's output pulse width, adds bias, saturates.
module td_mac_sequencer #(
  parameter int DW      = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [DW-1:0]    din,
  input  logic [DW-1:0]    win,
  input  logic [DW-1:0]    bias,
  input  logic             start,
  output logic             busy,
  output logic             in_pulse,
  output logic             w_pulse,
  output logic             cell_en,
  input  logic             cell_out,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, DRIVE, MEASURE, DONE} state_t;

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  state_t           state_q, state_d;
  logic [DW-1:0]    din_st_q, din_st_d, win_st_q, win_st_d, bias_st_q, bias_st_d;
  logic [DW-1:0]    din_s_q, din_s_d, win_s_q, win_s_d, bias_s_q, bias_s_d;
  logic             cfg_loaded_q, cfg_loaded_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, width_q, width_d, result_q, result_d;
  logic             seen_q, seen_d, busy_q, busy_d, rv_q, rv_d, timeout_q, timeout_d;
  logic [1:0]       sync_q, sync_d;
  logic [DW-1:0]    max_s;
  logic [CNT_W+1:0] sum;
  logic             cell_hi;

  always_comb begin
    max_s   = (din_s_q > win_s_q) ? din_s_q : win_s_q;
    // Two extra bits: MSB flags a negative sum, the next one an overflow past all-ones.
    sum     = {2'b00, width_q} + {{(CNT_W+2-DW){bias_s_q[DW-1]}}, bias_s_q};
    cell_hi = sync_q[1];
    sync_d  = {sync_q[0], cell_out};
  end

  always_comb begin
    state_d      = state_q;
    din_st_d     = din_st_q;
    win_st_d     = win_st_q;
    bias_st_d    = bias_st_q;
    din_s_d      = din_s_q;
    win_s_d      = win_s_q;
    bias_s_d     = bias_s_q;
    cfg_loaded_d = cfg_loaded_q;
    cnt_d        = cnt_q;
    width_d      = width_q;
    result_d     = result_q;
    seen_d       = seen_q;
    busy_d       = busy_q;
    rv_d         = 1'b0;
    timeout_d    = timeout_q;

    if (cfg_valid) begin
      din_st_d     = din;
      win_st_d     = win;
      bias_st_d    = bias;
      cfg_loaded_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && cfg_loaded_q) begin
          din_s_d   = din_st_q;
          win_s_d   = win_st_q;
          bias_s_d  = bias_st_q;
          cnt_d     = '0;
          width_d   = '0;
          seen_d    = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = (din_st_q == '0 && win_st_q == '0) ? DONE : DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(max_s) - 1'b1) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        cnt_d = cnt_q + 1'b1;
        if (cell_hi) begin
          seen_d  = 1'b1;
          width_d = (width_q == ALL_ONES) ? width_q : width_q + 1'b1;
        end
        if (!cell_hi && seen_q) begin
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          width_d   = ALL_ONES;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (sum[CNT_W+1])  result_d = '0;
        else if (sum[CNT_W]) result_d = ALL_ONES;
        else               result_d = sum[CNT_W-1:0];
        rv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      din_st_q     <= '0;
      win_st_q     <= '0;
      bias_st_q    <= '0;
      din_s_q      <= '0;
      win_s_q      <= '0;
      bias_s_q     <= '0;
      cfg_loaded_q <= 1'b0;
      cnt_q        <= '0;
      width_q      <= '0;
      result_q     <= '0;
      seen_q       <= 1'b0;
      busy_q       <= 1'b0;
      rv_q         <= 1'b0;
      timeout_q    <= 1'b0;
      sync_q       <= '0;
    end else begin
      state_q      <= state_d;
      din_st_q     <= din_st_d;
      win_st_q     <= win_st_d;
      bias_st_q    <= bias_st_d;
      din_s_q      <= din_s_d;
      win_s_q      <= win_s_d;
      bias_s_q     <= bias_s_d;
      cfg_loaded_q <= cfg_loaded_d;
      cnt_q        <= cnt_d;
      width_q      <= width_d;
      result_q     <= result_d;
      seen_q       <= seen_d;
      busy_q       <= busy_d;
      rv_q         <= rv_d;
      timeout_q    <= timeout_d;
      sync_q       <= sync_d;
    end
  end

  // Cell-side outputs decode straight from reset flops so they drop with rst.
  assign cell_en      = (state_q == DRIVE) || (state_q == MEASURE);
  assign in_pulse     = (state_q == DRIVE) && (cnt_q < CNT_W'(din_s_q));
  assign w_pulse      = (state_q == DRIVE) && (cnt_q < CNT_W'(win_s_q));
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_td_mac_sequencer.sv
// tb/tb_td_mac_sequencer.sv - self-checking bench for td_mac_sequencer
// Vector table, hand sequences and random runs scored against an arithmetic model.
module tb_td_mac_sequencer;

  localparam int TIMEOUT = 4095;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  din = '0, win = '0, bias = '0;
  logic        start = 1'b0;
  logic        busy, in_pulse, w_pulse, cell_en;
  logic        cell_out = 1'b0;
  logic [15:0] result;
  logic        result_valid, timeout_err;

  td_mac_sequencer #(.DW(8), .CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .din(din), .win(win), .bias(bias),
    .start(start), .busy(busy), .in_pulse(in_pulse), .w_pulse(w_pulse), .cell_en(cell_en),
    .cell_out(cell_out), .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  int          r_in, r_w, r_en, r_rv;
  logic [15:0] r_res;
  bit          r_toerr, r_tog, r_hung, r_busy0, r_to0, r_busy_after, r_rv_after;

  int          mid_cycle = -1;
  bit          mid_cfg = 0, mid_start = 0;
  logic [7:0]  mid_d, mid_w, mid_b;

  typedef struct {
    logic [7:0] d, w, b;
    int         pw, dly;
    bit         nf;
    int         exp_res;
    bit         exp_to;
  } vec_t;

  vec_t vecs[9];

  function automatic void chk(string nm, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic int model_res(int pw, logic [7:0] b, bit to, bit zero);
    int s;
    s = (zero ? 0 : (to ? 65535 : pw)) + int'($signed(b));
    if (s < 0) return 0;
    if (s > 65535) return 65535;
    return s;
  endfunction

  task automatic load_cfg(input logic [7:0] d, w, b);
    @(negedge clk);
    cfg_valid = 1'b1; din = d; win = w; bias = b;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic run_mac(input logic [7:0] d, w, b, input int pw, dly, input bit nf, input bit do_cfg);
    int mcyc;
    bit done, first;
    if (do_cfg) load_cfg(d, w, b);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    r_busy0 = busy; r_to0 = timeout_err;
    r_in = 0; r_w = 0; r_en = 0; r_rv = 0; r_res = '0; r_toerr = 0; r_tog = 1;
    mcyc = 0; done = 0; first = 1;
    for (int c = 0; c < 6000 && !done; c++) begin
      if (c > 0) @(negedge clk);
      cfg_valid = 1'b0; start = 1'b0;
      if (c == mid_cycle) begin
        if (mid_cfg) begin cfg_valid = 1'b1; din = mid_d; win = mid_w; bias = mid_b; end
        if (mid_start) start = 1'b1;
      end
      r_in += int'(in_pulse);
      r_w  += int'(w_pulse);
      r_en += int'(cell_en);
      if (cell_en && first) begin
        r_tog = (in_pulse == (d != 0)) && (w_pulse == (w != 0));
        first = 0;
      end
      if (cell_en && !in_pulse && !w_pulse) begin
        mcyc++;
        cell_out = nf ? (mcyc > dly) : (mcyc > dly && mcyc <= dly + pw);
      end else begin
        cell_out = 1'b0;
      end
      if (result_valid) begin
        r_rv++; r_res = result; r_toerr = timeout_err; done = 1;
      end
    end
    r_hung = !done;
    cell_out = 1'b0; cfg_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    r_busy_after = busy; r_rv_after = result_valid;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(string tag, int ei, int ew, int eres, bit eto);
    chk({tag, "_hung"}, r_hung, 0);
    chk({tag, "_busy_start"}, r_busy0, 1);
    chk({tag, "_to_cleared"}, r_to0, 0);
    chk({tag, "_in_cycles"}, r_in, ei);
    chk({tag, "_w_cycles"}, r_w, ew);
    chk({tag, "_together"}, r_tog, 1);
    chk({tag, "_result"}, r_res, eres);
    chk({tag, "_timeout_err"}, r_toerr, eto);
    chk({tag, "_rv_pulse"}, r_rv_after, 0);
    chk({tag, "_busy_after"}, r_busy_after, 0);
    if (ei == 0 && ew == 0) chk({tag, "_no_cell_en"}, r_en, 0);
    if (eto) chk({tag, "_to_cycles"}, r_en, ((ei > ew) ? ei : ew) + TIMEOUT);
  endtask

  initial begin
    int ok;
    logic [7:0] d, w, b;
    int pw, dly;

    vecs[0] = '{8'd127, 8'd12,  8'h01, 16,  2, 0, 17,    1'b0};
    vecs[1] = '{8'd0,   8'd0,   8'hFB, 0,   0, 0, 0,     1'b0};
    vecs[2] = '{8'd16,  8'd1,   8'h01, 0,   0, 1, 65535, 1'b1};
    vecs[3] = '{8'd5,   8'd9,   8'h80, 20,  1, 0, 0,     1'b0};
    vecs[4] = '{8'd3,   8'd3,   8'h7F, 200, 0, 0, 327,   1'b0};
    vecs[5] = '{8'd1,   8'd200, 8'hFF, 1,   3, 0, 0,     1'b0};
    vecs[6] = '{8'd200, 8'd0,   8'hF6, 50,  4, 0, 40,    1'b0};
    vecs[7] = '{8'd2,   8'd2,   8'hFE, 0,   0, 1, 65533, 1'b1};
    vecs[8] = '{8'd8,   8'd8,   8'h00, 1,   0, 0, 1,     1'b0};

    #3;
    chk("reset_busy", busy, 0);
    chk("reset_cell_en", cell_en, 0);
    chk("reset_pulses", {in_pulse, w_pulse}, 0);
    chk("reset_result", result, 0);
    chk("reset_rv_to", {result_valid, timeout_err}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // start with nothing configured must be ignored
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1;
    repeat (5) begin
      if (busy || cell_en || in_pulse || w_pulse || result_valid) ok = 0;
      @(negedge clk);
    end
    chk("nocfg_ignored", ok, 1);
    chk("nocfg_result", result, 0);

    foreach (vecs[i])
      begin
        run_mac(vecs[i].d, vecs[i].w, vecs[i].b, vecs[i].pw, vecs[i].dly, vecs[i].nf, 1'b1);
        check_run($sformatf("vec%0d", i), vecs[i].d, vecs[i].w, vecs[i].exp_res, vecs[i].exp_to);
      end

    // cfg_valid mid-DRIVE only touches staging; next run picks it up
    mid_cycle = 30; mid_cfg = 1; mid_start = 0; mid_d = 8'd1; mid_w = 8'd1; mid_b = 8'd0;
    run_mac(8'd127, 8'd12, 8'd1, 16, 2, 0, 1'b1);
    mid_cycle = -1; mid_cfg = 0;
    check_run("midcfg_cur", 127, 12, 17, 0);
    run_mac(8'd1, 8'd1, 8'd0, 4, 0, 0, 1'b0);
    check_run("midcfg_next", 1, 1, 4, 0);

    // start while busy is ignored
    mid_cycle = 5; mid_start = 1;
    run_mac(8'd20, 8'd7, 8'd3, 9, 1, 0, 1'b1);
    mid_cycle = -1; mid_start = 0;
    check_run("busy_start", 20, 7, 12, 0);
    chk("busy_start_no_rerun", busy, 0);

    for (int k = 0; k < 25; k++) begin
      d = 8'($urandom_range(0, 40));
      w = 8'($urandom_range(0, 40));
      b = 8'($urandom);
      pw = $urandom_range(1, 60);
      dly = $urandom_range(0, 4);
      run_mac(d, w, b, pw, dly, 0, 1'b1);
      check_run($sformatf("rnd%0d", k), d, w, model_res(pw, b, 0, (d == 0 && w == 0)), 0);
    end

    // async reset in MEASURE
    load_cfg(8'd10, 8'd10, 8'd0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (cell_en && !in_pulse && !w_pulse) ok = 1;
      else @(negedge clk);
    end
    chk("rst_reach_measure", ok, 1);
    cell_out = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_cell_en", cell_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    cell_out = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1;
    repeat (4) begin
      if (busy || cell_en) ok = 0;
      @(negedge clk);
    end
    chk("rst_start_ignored", ok, 1);
    run_mac(8'd4, 8'd6, 8'h02, 5, 0, 0, 1'b1);
    check_run("post_rst", 4, 6, 7, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
